// File: rtl/fetch_ctrl_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl_pipe_pkg
//  Description : Shared types and constants for the fetch-stage controller:
//                FSM state encoding, PC mux encodings, default CF opcode.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_ctrl_pipe_pkg;

  // CF_WAIT is the only state with the top bit set, so cf_pending can be
  // taken straight from that state flop bit.
  typedef enum logic [3:0] {
    ST_IDLE     = 4'b0000,
    ST_RUN      = 4'b0001,
    ST_MEM_WAIT = 4'b0010,
    ST_HOLD     = 4'b0011,
    ST_REDIRECT = 4'b0100,
    ST_CF_WAIT  = 4'b1000
  } fetch_state_t;

  localparam int CF_WAIT_BIT = 3;

  // PC mux select encodings
  localparam logic [1:0] PCSEL_HOLD = 2'd0;
  localparam logic [1:0] PCSEL_INC  = 2'd1;
  localparam logic [1:0] PCSEL_TGT  = 2'd2;

  // Opcode that marks a branch/jump
  localparam logic [3:0] CF_OPC_DEFAULT = 4'b0001;

endpackage : fetch_ctrl_pipe_pkg
`default_nettype wire

// File: rtl/fetch_ctrl_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl_pipe_if
//  Description : Pipeline-status inputs and fetch-control outputs of the
//                fetch-stage controller. master = controller, slave = the
//                pipeline/memory side that observes it.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_ctrl_pipe_if #(
  parameter int STAGES = 3,
  parameter int OPW    = 4,
  parameter int CNT_W  = 8
);
  // Pipeline status towards the controller
  logic [STAGES*OPW-1:0] stage_opc;
  logic [STAGES-1:0]     stage_valid;
  logic                  mem_ready;
  logic                  redirect_valid;
  logic                  ext_stall;

  // Fetch control from the controller
  logic                  mem_read;
  logic                  pc_write;
  logic [1:0]            pc_sel;
  logic                  ir1_load;
  logic                  ir1_bubble;
  logic                  cf_pending;
  logic [CNT_W-1:0]      stall_count;
  logic                  cf_timeout;

  modport master (
    input  stage_opc, stage_valid, mem_ready, redirect_valid, ext_stall,
    output mem_read, pc_write, pc_sel, ir1_load, ir1_bubble,
           cf_pending, stall_count, cf_timeout
  );

  modport slave (
    output stage_opc, stage_valid, mem_ready, redirect_valid, ext_stall,
    input  mem_read, pc_write, pc_sel, ir1_load, ir1_bubble,
           cf_pending, stall_count, cf_timeout
  );

endinterface : fetch_ctrl_pipe_if
`default_nettype wire

// File: rtl/fetch_ctrl_pipe_cf_hazard_detect.sv
`default_nettype none
// ============================================================================
//  Module      : cf_hazard_detect
//  Description : Combinational control-flow hazard detector. Flags when any
//                valid downstream stage (index 0 = IR1) holds the CF opcode.
//  Revision    : 1.0 - initial release
// ============================================================================
module cf_hazard_detect
  import fetch_ctrl_pipe_pkg::*;
#(
  parameter int             STAGES = 3,
  parameter int             OPW    = 4,
  parameter logic [OPW-1:0] CF_OPC = OPW'(CF_OPC_DEFAULT)
) (
  input  logic [STAGES*OPW-1:0] stage_opc,
  input  logic [STAGES-1:0]     stage_valid,
  output logic                  hazard
);

  logic [STAGES-1:0] stage_match;

  generate
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
      assign stage_match[i] = stage_valid[i] && (stage_opc[i*OPW +: OPW] == CF_OPC);
    end
  endgenerate

  assign hazard = |stage_match;

endmodule : cf_hazard_detect
`default_nettype wire

// File: rtl/fetch_ctrl_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl_pipe
//  Description : Fetch-stage controller. Drives I-mem read, PC write/select
//                and IR1 load/bubble; stalls on in-flight control flow,
//                memory wait-states and external stalls; takes branch
//                redirects; counts stall cycles with a sticky timeout flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl_pipe
  import fetch_ctrl_pipe_pkg::*;
#(
  parameter int             OPW         = 4,
  parameter int             STAGES      = 3,
  parameter logic [OPW-1:0] CF_OPC      = OPW'(CF_OPC_DEFAULT),
  parameter int             CNT_W       = 8,
  parameter int             MAX_CF_WAIT = 16
) (
  input  logic              clock,
  input  logic              reset,
  fetch_ctrl_pipe_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_SAT      = {CNT_W{1'b1}};
  localparam logic [31:0]      MAX_CF_WAIT_U = MAX_CF_WAIT;

  fetch_state_t     state;
  fetch_state_t     next_state;
  logic [CNT_W-1:0] next_count;
  logic             hazard;

  cf_hazard_detect #(
    .STAGES (STAGES),
    .OPW    (OPW),
    .CF_OPC (CF_OPC)
  ) u_cf_hazard_detect (
    .stage_opc   (bus.stage_opc),
    .stage_valid (bus.stage_valid),
    .hazard      (hazard)
  );

  // Priority decision: redirect > hazard > memory wait > external stall > run.
  // Every state (IDLE included) re-evaluates the full list each edge.
  always_comb begin
    next_state = ST_RUN;
    if (bus.redirect_valid)  next_state = ST_REDIRECT;
    else if (hazard)         next_state = ST_CF_WAIT;
    else if (!bus.mem_ready) next_state = ST_MEM_WAIT;
    else if (bus.ext_stall)  next_state = ST_HOLD;
  end

  // Stall counter: cleared on entering RUN, otherwise saturating increment.
  always_comb begin
    next_count = '0;
    if (next_state == ST_RUN)          next_count = '0;
    else if (bus.stall_count == CNT_SAT) next_count = CNT_SAT;
    else                               next_count = bus.stall_count + 1'b1;
  end

  // State register with registered fetch-control outputs for the next state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= ST_IDLE;
      bus.mem_read    <= 1'b1;
      bus.pc_write    <= 1'b0;
      bus.pc_sel      <= PCSEL_HOLD;
      bus.ir1_load    <= 1'b0;
      bus.ir1_bubble  <= 1'b0;
      bus.stall_count <= '0;
      bus.cf_timeout  <= 1'b0;
    end else begin
      state           <= next_state;
      bus.mem_read    <= 1'b1;
      bus.stall_count <= next_count;
      // Sticky: rises in the same cycle the count shows the limit in CF_WAIT.
      if ((next_state == ST_CF_WAIT) && (32'(next_count) >= MAX_CF_WAIT_U))
        bus.cf_timeout <= 1'b1;
      case (next_state)
        ST_REDIRECT: begin
          bus.pc_write   <= 1'b1;
          bus.pc_sel     <= PCSEL_TGT;
          bus.ir1_load   <= 1'b0;
          bus.ir1_bubble <= 1'b1;
        end
        ST_CF_WAIT: begin
          bus.pc_write   <= 1'b0;
          bus.pc_sel     <= PCSEL_HOLD;
          bus.ir1_load   <= 1'b0;
          bus.ir1_bubble <= 1'b1;
        end
        ST_MEM_WAIT, ST_HOLD: begin
          // IR1 keeps its previous word
          bus.pc_write   <= 1'b0;
          bus.pc_sel     <= PCSEL_HOLD;
          bus.ir1_load   <= 1'b0;
          bus.ir1_bubble <= 1'b0;
        end
        default: begin
          bus.pc_write   <= 1'b1;
          bus.pc_sel     <= PCSEL_INC;
          bus.ir1_load   <= 1'b1;
          bus.ir1_bubble <= 1'b0;
        end
      endcase
    end
  end

  // Direct flop bit: only the CF_WAIT encoding has it set.
  assign bus.cf_pending = state[CF_WAIT_BIT];

endmodule : fetch_ctrl_pipe
`default_nettype wire

// File: tb/tb_fetch_ctrl_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_ctrl_pipe
//  Description : Self-checking bench for fetch_ctrl_pipe. A reference model
//                pushes the expected outputs for each driven cycle into a
//                queue; they are popped and compared after the clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl_pipe;
  import fetch_ctrl_pipe_pkg::*;

  localparam int STAGES      = 3;
  localparam int OPW         = 4;
  localparam int CNT_W       = 8;
  localparam int MAX_CF_WAIT = 16;

  localparam logic [11:0] OPC_NONE = 12'h234;  // no CF opcode in any stage
  localparam logic [11:0] OPC_S0   = 12'h231;  // CF opcode in IR1
  localparam logic [11:0] OPC_S1   = 12'h214;  // CF opcode in stage 1
  localparam logic [11:0] OPC_S2   = 12'h134;  // CF opcode in stage 2
  localparam logic [11:0] OPC_ALL  = 12'h111;  // CF opcode everywhere

  typedef struct packed {
    logic             mem_read;
    logic             pc_write;
    logic [1:0]       pc_sel;
    logic             ir1_load;
    logic             ir1_bubble;
    logic             cf_pending;
    logic [CNT_W-1:0] stall_count;
    logic             cf_timeout;
  } exp_t;

  logic clock = 1'b0;
  logic reset;

  fetch_ctrl_pipe_if #(.STAGES(STAGES), .OPW(OPW), .CNT_W(CNT_W)) bus ();

  fetch_ctrl_pipe #(
    .OPW         (OPW),
    .STAGES      (STAGES),
    .CF_OPC      (4'b0001),
    .CNT_W       (CNT_W),
    .MAX_CF_WAIT (MAX_CF_WAIT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  exp_t exp_q[$];
  int   num_checks = 0;
  int   num_fails  = 0;
  int   m_count    = 0;
  logic m_timeout  = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] actual,
                           input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    check_val({tag, ".mem_read"},    32'(bus.mem_read),    32'(e.mem_read));
    check_val({tag, ".pc_write"},    32'(bus.pc_write),    32'(e.pc_write));
    check_val({tag, ".pc_sel"},      32'(bus.pc_sel),      32'(e.pc_sel));
    check_val({tag, ".ir1_load"},    32'(bus.ir1_load),    32'(e.ir1_load));
    check_val({tag, ".ir1_bubble"},  32'(bus.ir1_bubble),  32'(e.ir1_bubble));
    check_val({tag, ".cf_pending"},  32'(bus.cf_pending),  32'(e.cf_pending));
    check_val({tag, ".stall_count"}, 32'(bus.stall_count), 32'(e.stall_count));
    check_val({tag, ".cf_timeout"},  32'(bus.cf_timeout),  32'(e.cf_timeout));
  endtask

  task automatic check_reset_values(input string tag);
    exp_t e;
    e = '0;
    e.mem_read = 1'b1;
    check_outputs(tag, e);
  endtask

  // Reference model: outputs expected after the next edge for these inputs.
  task automatic model(input logic [11:0] opc, input logic [2:0] valid,
                       input logic mr, input logic rv, input logic es,
                       output exp_t e);
    logic hz;
    hz = 1'b0;
    for (int i = 0; i < STAGES; i++)
      if (valid[i] && (opc[i*OPW +: OPW] == 4'b0001)) hz = 1'b1;
    e = '0;
    e.mem_read = 1'b1;
    if (rv) begin
      e.pc_write = 1'b1; e.pc_sel = 2'd2; e.ir1_bubble = 1'b1;
    end else if (hz) begin
      e.ir1_bubble = 1'b1; e.cf_pending = 1'b1;
    end else if (!mr || es) begin
      // MEM_WAIT or HOLD: everything quiet, IR1 held
    end else begin
      e.pc_write = 1'b1; e.pc_sel = 2'd1; e.ir1_load = 1'b1;
    end
    if (e.ir1_load) m_count = 0;
    else if (m_count < 255) m_count++;
    e.stall_count = CNT_W'(m_count);
    if (e.cf_pending && m_count >= MAX_CF_WAIT) m_timeout = 1'b1;
    e.cf_timeout = m_timeout;
  endtask

  // Drive one cycle of inputs, queue the expectation, compare after the edge.
  task automatic step(input logic [11:0] opc, input logic [2:0] valid,
                      input logic mr, input logic rv, input logic es,
                      input string tag);
    exp_t e;
    bus.stage_opc      = opc;
    bus.stage_valid    = valid;
    bus.mem_ready      = mr;
    bus.redirect_valid = rv;
    bus.ext_stall      = es;
    model(opc, valid, mr, rv, es, e);
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    if (exp_q.size() == 0) begin
      check_val({tag, ".queue"}, 32'(0), 32'(1));
    end else begin
      e = exp_q.pop_front();
      check_outputs(tag, e);
    end
    @(negedge clock);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset              = 1'b1;
    bus.stage_opc      = OPC_NONE;
    bus.stage_valid    = 3'b000;
    bus.mem_ready      = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.ext_stall      = 1'b0;
    #2;
    check_reset_values("reset");
    @(negedge clock);
    reset = 1'b0;
    m_count = 0; m_timeout = 1'b0;
    #1;
    check_reset_values("idle");

    // Plain fetch
    repeat (5) step(OPC_NONE, 3'b111, 1'b1, 1'b0, 1'b0, "run");
    step(OPC_ALL, 3'b000, 1'b1, 1'b0, 1'b0, "cf_invalid_stages");

    // Branch in stage 1 for 3 cycles, then cleared
    repeat (3) step(OPC_S1, 3'b010, 1'b1, 1'b0, 1'b0, "cf_wait");
    step(OPC_NONE, 3'b111, 1'b1, 1'b0, 1'b0, "cf_exit");

    // Redirect during CF_WAIT with hazard still present
    step(OPC_S1, 3'b010, 1'b1, 1'b0, 1'b0, "cf_wait2");
    step(OPC_S1, 3'b010, 1'b1, 1'b1, 1'b0, "redirect_over_hazard");
    step(OPC_S1, 3'b010, 1'b1, 1'b0, 1'b0, "hazard_recheck");
    step(OPC_NONE, 3'b111, 1'b1, 1'b0, 1'b0, "run2");
    step(OPC_NONE, 3'b111, 1'b0, 1'b1, 1'b1, "redirect_over_mem");

    // Memory wait-states beat external stall, then HOLD
    repeat (2) step(OPC_NONE, 3'b111, 1'b0, 1'b0, 1'b1, "mem_wait");
    repeat (2) step(OPC_NONE, 3'b111, 1'b1, 1'b0, 1'b1, "hold");
    step(OPC_S2, 3'b100, 1'b0, 1'b0, 1'b1, "cf_over_mem");
    step(OPC_NONE, 3'b111, 1'b1, 1'b0, 1'b0, "run3");

    // Long hazard in IR1: timeout at count 16, sticky afterwards
    repeat (20) step(OPC_S0, 3'b001, 1'b1, 1'b0, 1'b0, "cf_long");
    repeat (3) step(OPC_NONE, 3'b111, 1'b1, 1'b0, 1'b0, "after_timeout");
    check_val("timeout_sticky", 32'(bus.cf_timeout), 32'(1));

    // Counter saturation
    repeat (260) step(OPC_S0, 3'b001, 1'b1, 1'b0, 1'b0, "cf_saturate");
    step(OPC_NONE, 3'b111, 1'b1, 1'b0, 1'b0, "run4");

    // Asynchronous reset between clock edges during CF_WAIT
    repeat (2) step(OPC_S1, 3'b010, 1'b1, 1'b0, 1'b0, "pre_reset");
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("async_reset");
    m_count = 0; m_timeout = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_reset_values("post_reset_idle");
    step(OPC_S1, 3'b010, 1'b1, 1'b0, 1'b0, "idle_to_cf_wait");
    step(OPC_NONE, 3'b111, 1'b1, 1'b0, 1'b0, "run5");

    // Random traffic
    repeat (200) begin
      logic [11:0] r_opc;
      logic [2:0]  r_valid;
      r_opc   = 12'($urandom_range(0, 4095));
      r_valid = 3'($urandom_range(0, 7));
      step(r_opc, r_valid, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) == 0), "random");
    end

    check_val("queue_empty", 32'(exp_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule : tb_fetch_ctrl_pipe
`default_nettype wire
